// File: rtl/vsa_dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two VSA cores.
// It holds one transaction at a time: grant, memory issue with timeout, one-cycle completion.
module vsa_dmem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_done0,
  output logic          o_done1,
  output logic          o_err0,
  output logic          o_err1,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_busy,
  output logic          o_gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_last;
  logic [7:0]    r_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_done0;
  logic          r_done1;
  logic          r_err0;
  logic          r_err1;
  logic          r_busy;
  logic          r_gnt_id;

  logic          w_any_req;
  logic          w_pick;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_any_req = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      w_pick = ~r_last;
    end else begin
      w_pick = i_req1;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_rdata     <= {DW{1'b0}};
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_busy      <= 1'b0;
      r_gnt_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state     <= S_ISSUE;
            r_gnt_id    <= w_pick;
            r_mem_we    <= w_pick ? i_we1    : i_we0;
            r_mem_addr  <= w_pick ? i_addr1  : i_addr0;
            r_mem_wdata <= w_pick ? i_wdata1 : i_wdata0;
            r_cnt       <= 8'd0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (i_mem_ack) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_rdata   <= r_mem_we ? {DW{1'b0}} : i_mem_rdata;
            r_done0   <= ~r_gnt_id;
            r_done1   <= r_gnt_id;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_rdata   <= {DW{1'b0}};
            r_done0   <= ~r_gnt_id;
            r_done1   <= r_gnt_id;
            r_err0    <= ~r_gnt_id;
            r_err1    <= r_gnt_id;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_last  <= r_gnt_id;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_done0   <= 1'b0;
          r_done1   <= 1'b0;
          r_err0    <= 1'b0;
          r_err1    <= 1'b0;
        end
      endcase
    end
  end

  assign o_done0     = r_done0;
  assign o_done1     = r_done1;
  assign o_err0      = r_err0;
  assign o_err1      = r_err1;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_vsa_dmem_arbiter.sv
// Bench for vsa_dmem_arbiter: directed scenarios, a per-cycle reference model,
// and literal expectations on completion events.
module tb_vsa_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] mem_rd_val = '0;
  logic mem_ack;
  logic stray_ack = 1'b0;
  int   ack_delay = 255;
  int   cyc = 0;

  logic o_done0, o_done1, o_err0, o_err1, o_mem_req, o_mem_we, o_busy, o_gnt_id;
  logic [DW-1:0] o_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;

  vsa_dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_mem_rdata(mem_rd_val), .i_mem_ack(mem_ack),
    .o_done0(o_done0), .o_done1(o_done1), .o_err0(o_err0), .o_err1(o_err1),
    .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy), .o_gnt_id(o_gnt_id)
  );

  always #5 clk = ~clk;

  // Memory responder: acknowledges in the ack_delay-th cycle of a strobe (0 = zero-wait).
  always @(posedge clk) cyc <= o_mem_req ? cyc + 1 : 0;
  assign mem_ack = (o_mem_req && (cyc == ack_delay)) || stray_ack;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: transaction phase 0=idle, 1=memory busy, 2=completion.
  int m_ph, m_wait;
  logic m_last, m_gnt, m_we, m_req, m_busy, m_d0, m_d1, m_e0, m_e1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_last = 1'b1; m_gnt = 1'b0; m_we = 1'b0; m_req = 1'b0;
    m_busy = 1'b0; m_d0 = 1'b0; m_d1 = 1'b0; m_e0 = 1'b0; m_e1 = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic finish_txn(input logic is_err, input logic [DW-1:0] data);
    m_ph = 2; m_req = 1'b0; m_rdata = data;
    m_d0 = !m_gnt; m_d1 = m_gnt;
    m_e0 = is_err && !m_gnt; m_e1 = is_err && m_gnt;
  endtask

  task automatic model_step();
    if (m_ph == 0) begin
      if (req0 || req1) begin
        m_gnt = (req0 && req1) ? !m_last : req1;
        m_we = m_gnt ? we1 : we0;
        m_addr = m_gnt ? addr1 : addr0;
        m_wdata = m_gnt ? wdata1 : wdata0;
        m_ph = 1; m_wait = 0; m_req = 1'b1; m_busy = 1'b1;
      end
    end else if (m_ph == 1) begin
      if (mem_ack) finish_txn(1'b0, m_we ? '0 : mem_rd_val);
      else if (m_wait == TIMEOUT - 1) finish_txn(1'b1, '0);
      else m_wait++;
    end else begin
      m_ph = 0; m_last = m_gnt; m_busy = 1'b0;
      m_d0 = 1'b0; m_d1 = 1'b0; m_e0 = 1'b0; m_e1 = 1'b0;
    end
  endtask

  typedef struct { int id; logic err; logic [DW-1:0] rdata; int at; } ev_t;
  ev_t evq[$];
  int ncyc = 0;
  int run = 0;
  int last_run = 0;

  initial model_reset();

  // Compare process: check DUT against the model each cycle, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("cycle_outputs",
        {9'd0, o_done0, o_done1, o_err0, o_err1, o_rdata, o_mem_req, o_mem_we,
         o_mem_addr, o_mem_wdata, o_busy, o_gnt_id},
        {9'd0, m_d0, m_d1, m_e0, m_e1, m_rdata, m_req, m_we,
         m_addr, m_wdata, m_busy, m_gnt});
    if (o_mem_req) run++;
    else if (run > 0) begin last_run = run; run = 0; end
    if (o_done0 || o_done1)
      evq.push_back('{id: int'(o_done1), err: o_err0 | o_err1, rdata: o_rdata, at: ncyc});
    if (rst_n) model_step();
    ncyc++;
  end

  logic drop0 = 1'b1, drop1 = 1'b1;

  // One clock; a requester that saw its done pulse releases its request at the edge.
  task automatic tick();
    logic dd0, dd1;
    @(negedge clk);
    dd0 = o_done0; dd1 = o_done1;
    @(posedge clk);
    #1;
    if (dd0 && drop0) req0 = 1'b0;
    if (dd1 && drop1) req1 = 1'b0;
  endtask

  task automatic wait_events(input string nm, input int n, input int budget);
    int start = evq.size();
    int k = 0;
    while (evq.size() < start + n && k < budget) begin tick(); k++; end
    chk(nm, 32'(evq.size() >= start + n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    repeat (2) tick();
    chk("reset_outputs",
        {9'd0, o_done0, o_done1, o_err0, o_err1, o_rdata, o_mem_req, o_mem_we,
         o_mem_addr, o_mem_wdata, o_busy, o_gnt_id}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single load by requester 0
    ack_delay = 1; mem_rd_val = 5'h13;
    base = evq.size();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h0A;
    wait_events("load_done_seen", 1, 20);
    repeat (3) tick();
    chk("load_event_count", evq.size() - base, 1);
    chk("load_id", evq[base].id, 0);
    chk("load_err", evq[base].err, 0);
    chk("load_rdata", evq[base].rdata, 32'h13);
    chk("load_mem_req_cycles", last_run, 2);
    chk("load_mem_addr", o_mem_addr, 32'h0A);
    chk("load_mem_we", o_mem_we, 0);

    // Contention from reset with zero-wait memory
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ack_delay = 0; drop0 = 1'b0; drop1 = 1'b0;
    base = evq.size();
    req0 = 1'b1; req1 = 1'b1;
    wait_events("cont_done_seen", 4, 40);
    req0 = 1'b0; req1 = 1'b0; drop0 = 1'b1; drop1 = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("cont_order_%0d", i), evq[base+i].id, i % 2);
    for (int i = 1; i < 4; i++)
      chk($sformatf("cont_spacing_%0d", i), evq[base+i].at - evq[base+i-1].at, 3);

    // Store by requester 1
    ack_delay = 2; mem_rd_val = 5'h0E;
    base = evq.size();
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'h1F; wdata1 = 5'h15;
    wait_events("store_done_seen", 1, 20);
    repeat (2) tick();
    chk("store_id", evq[base].id, 1);
    chk("store_rdata", evq[base].rdata, 0);
    chk("store_mem_we", o_mem_we, 1);
    chk("store_mem_addr", o_mem_addr, 32'h1F);
    chk("store_mem_wdata", o_mem_wdata, 32'h15);

    // Timeout with no acknowledge, then acknowledge on the final allowed cycle
    ack_delay = 255; mem_rd_val = 5'h07;
    base = evq.size();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h03;
    wait_events("tmo_done_seen", 1, 40);
    repeat (2) tick();
    chk("tmo_err", evq[base].err, 1);
    chk("tmo_rdata", evq[base].rdata, 0);
    chk("tmo_mem_req_cycles", last_run, 15);
    ack_delay = 14;
    base = evq.size();
    req0 = 1'b1;
    wait_events("late_ack_done_seen", 1, 40);
    repeat (2) tick();
    chk("late_ack_err", evq[base].err, 0);
    chk("late_ack_rdata", evq[base].rdata, 32'h07);
    chk("late_ack_mem_req_cycles", last_run, 15);

    // Reset in the middle of requester 1's memory access
    ack_delay = 255;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'h11;
    repeat (3) tick();
    chk("pre_reset_gnt", o_gnt_id, 1);
    base = evq.size();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_gnt_id", o_gnt_id, 0);
    tick(); tick();
    ack_delay = 1; mem_rd_val = 5'h19;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_gnt", o_gnt_id, 1);
    chk("post_reset_mem_req", o_mem_req, 1);
    chk("rst_no_done", evq.size() - base, 0);
    wait_events("post_reset_done_seen", 1, 20);
    repeat (2) tick();
    chk("post_reset_rdata", o_rdata, 32'h19);

    // Stray acknowledges in IDLE and in DONE
    base = evq.size();
    mem_rd_val = 5'h02; stray_ack = 1'b1;
    repeat (2) tick();
    stray_ack = 1'b0;
    tick();
    chk("stray_idle_no_event", evq.size() - base, 0);
    chk("stray_idle_rdata", o_rdata, 32'h19);
    chk("stray_idle_busy", o_busy, 0);
    ack_delay = 0; mem_rd_val = 5'h0C;
    req0 = 1'b1; addr0 = 5'h04;
    for (int k = 0; k < 20 && !o_done0; k++) tick();
    chk("stray_done_reached", o_done0, 1);
    mem_rd_val = 5'h1B; stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    repeat (3) tick();
    chk("stray_done_events", evq.size() - base, 1);
    chk("stray_done_rdata", o_rdata, 32'h0C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vsa_dmem_arbiter.md
# vsa_dmem_arbiter

Round-robin arbiter sharing one single-port data memory between two VSA cores (requester 0 and 1). Each core's load/store path issues a held request; the arbiter selects one, drives the memory with registered address/data/write-enable, waits for the memory acknowledge (with a timeout), and returns read data plus a one-cycle completion pulse. It sits between the cores' data-cache ports (ALU address, data out/in, write strobe) and the shared memory.

## Interface
- AW, 5, address width (matches core ALU output width)
- DW, 5, data width (matches core data bus)
- TIMEOUT, 15, max cycles in ISSUE without mem_ack before abort; legal 1..255
- clock  input  1  master clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  request from requester k; held high until done_k
- we0 / we1  input  1  1 = store, 0 = load; stable while req_k high
- addr0 / addr1  input  AW  address; stable while req_k high
- wdata0 / wdata1  input  DW  store data; stable while req_k high
- done0 / done1  output  1  one-cycle completion pulse for requester k
- err0 / err1  output  1  high together with done_k when transaction timed out
- rdata  output  DW  load data, valid while done0 or done1 is high
- mem_req  output  1  memory access strobe, held until acknowledged or timed out
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion, sampled only in ISSUE
- busy  output  1  high in ISSUE and DONE
- gnt_id  output  1  requester currently/last granted

## Operation
- Reset (async, reset_n=0): state IDLE; last-served pointer = 1 (so requester 0 wins first tie); all outputs 0, including mem_req, done_k, err_k, rdata, gnt_id, busy; timeout counter 0.
- States: IDLE, ISSUE, DONE. DONE always returns to IDLE.
- IDLE: if exactly one req_k high, grant k. If both high, grant the requester not equal to last-served. On grant: latch we_k/addr_k/wdata_k into mem_we/mem_addr/mem_wdata, gnt_id=k, counter=0, go ISSUE. No request: stay IDLE.
- ISSUE: mem_req=1. If mem_ack=1: capture mem_rdata into rdata (loads only; stores leave rdata = 0), go DONE, err=0. Else if counter == TIMEOUT-1: go DONE with err=1, rdata=0. Else counter+1. mem_ack and timeout on same cycle: ack wins, err=0.
- DONE: done_gnt_id=1 (and err_gnt_id if aborted) for exactly this cycle; last-served := gnt_id; mem_req=0; go IDLE.
- mem_ack outside ISSUE ignored. Dropping req_k during ISSUE is a protocol violation; the transaction still completes and done_k still pulses.
- mem_we/mem_addr/mem_wdata hold their latched values until the next grant.
- Requester observing done_k drops req_k at that same edge; a req_k still high in IDLE afterwards is a new request.

## Timing
- Outputs all registered; no combinational path input->output.
- req_k sampled high at edge E0 -> mem_req high from E0; mem_ack sampled at edge E1 -> done_k high cycle after E1. Minimum request-to-done: 2 cycles.
- Minimum transaction period: 3 cycles (IDLE, ISSUE, DONE); zero-wait-state memory gives 1/3 throughput with alternating grants under contention.
- Timeout: exactly TIMEOUT cycles of mem_req high, then one DONE cycle with err.
- Reset asserted mid-ISSUE: mem_req drops immediately (asynchronously), no done pulse; after release, pending requests re-arbitrate from IDLE with requester 0 preferred.

## Test plan
- Single load: req0=1, we0=0, addr0=5'h0A, mem_ack one cycle after mem_req with mem_rdata=5'h13 -> mem_addr=0x0A, mem_we=0, done0 pulse 1 cycle, rdata=0x13, err0=0, done1 never.
- Contention: req0=req1=1 from reset, zero-wait memory, both held after done -> grant order 0,1,0,1; each done separated by 3 cycles; gnt_id alternates.
- Store: req1=1, we1=1, addr1=0x1F, wdata1=0x15 -> mem_we=1, mem_addr=0x1F, mem_wdata=0x15 while mem_req high; done1 pulse; rdata=0.
- Timeout: TIMEOUT=15, req0 held, mem_ack never -> mem_req high exactly 15 cycles, then done0=err0=1 one cycle, rdata=0; ack on cycle 15 instead -> err0=0.
- Reset mid-operation: reset_n low while ISSUE -> mem_req, busy, gnt_id 0 immediately; no done; after release with req1 alone high -> requester 1 granted next edge.
- Stray ack: mem_ack pulsed in IDLE and DONE -> no state change, no extra done, rdata unchanged.
